// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record used by the
// writeback scheduler and its source-B buffer.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// Synchronous FIFO (wb_fifo) with valid/ready on both sides; DEPTH must be a power of two.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t
) (
    input  logic clk,
    input  logic reset,
    input  logic i_in_valid,
    output logic o_in_ready,
    input  T     i_in_data,
    output logic o_out_valid,
    input  logic i_out_ready,
    output T     o_out_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    T            r_mem [DEPTH];
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Ready depends only on stored state, so a full buffer never pushes in the same cycle it pops.
    assign w_push  = i_in_valid && !w_full;
    assign w_pop   = !w_empty && i_out_ready;

    assign o_in_ready  = !w_full;
    assign o_out_valid = !w_empty;
    assign o_out_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_in_data;
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the RegFile write port between the WB stage (A) and a buffered long-latency
// source (B), and tracks pending B writes for decode stalls. Optional: WB_CONFLICT_CNT_EN.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] readreg1,
    input  logic [ADDR_W-1:0] readreg2,
    output logic              stall,
    output logic              regwrite,
    output logic [ADDR_W-1:0] writereg,
    output logic [DATA_W-1:0] writedata
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);
    localparam int NREGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              w_b_in;
    req_t              w_head;
    logic              w_head_valid;
    logic              w_b_pop;
    logic [NREGS-1:0]  w_set;
    logic [NREGS-1:0]  w_clr;
    logic [NREGS-1:0]  r_pend;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_writereg;
    logic [DATA_W-1:0] r_writedata;

    assign w_b_in = {b_reg, b_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (b_valid),
        .o_in_ready  (b_ready),
        .i_in_data   (w_b_in),
        .o_out_valid (w_head_valid),
        .i_out_ready (!a_valid),
        .o_out_data  (w_head)
    );

    // A has fixed priority; the B head only drains in cycles without an A write.
    assign w_b_pop = w_head_valid && !a_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_regwrite  <= 1'b0;
            r_writereg  <= '0;
            r_writedata <= '0;
        end else if (a_valid) begin
            r_regwrite  <= (a_reg != '0);
            r_writereg  <= a_reg;
            r_writedata <= a_data;
        end else if (w_b_pop) begin
            r_regwrite  <= (w_head.rd != '0);
            r_writereg  <= w_head.rd;
            r_writedata <= w_head.data;
        end else begin
            r_regwrite  <= 1'b0;
        end
    end

    assign regwrite  = r_regwrite;
    assign writereg  = r_writereg;
    assign writedata = r_writedata;

    assign stall = (r_pend[readreg1] && (readreg1 != '0)) ||
                   (r_pend[readreg2] && (readreg2 != '0)) ||
                   (issue_valid && r_pend[issue_reg] && (issue_reg != '0));

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && !stall && (issue_reg != '0)) w_set[issue_reg] = 1'b1;
        if (w_b_pop) w_clr[w_head.rd] = 1'b1;
    end

    // Set is OR-ed after the clear so a new issue survives a same-cycle retire.
    always_ff @(posedge clk) begin
        if (!reset) r_pend <= '0;
        else        r_pend <= (r_pend & ~w_clr) | w_set;
    end

`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_conflict_cnt <= '0;
        end else if (a_valid && w_head_valid && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed, table-driven bench for regfile_wb_scheduler plus hand-written reset sequences.
module tb_regfile_wb_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [4:0]  readreg1;
    logic [4:0]  readreg2;
    logic        stall;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_reg       (a_reg),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_reg       (b_reg),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .readreg1    (readreg1),
        .readreg2    (readreg2),
        .stall       (stall),
        .regwrite    (regwrite),
        .writereg    (writereg),
        .writedata   (writedata)
`ifdef WB_CONFLICT_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_stall;
        logic        e_bready;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
    } vec_t;

    vec_t tv [23];

    function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                                logic bv, logic [4:0] br, logic [31:0] bd,
                                logic iv, logic [4:0] ir, logic [4:0] r1, logic [4:0] r2,
                                logic es, logic eb, logic erw, logic [4:0] ewr, logic [31:0] ewd);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad;
        v.bv = bv; v.br = br; v.bd = bd;
        v.iv = iv; v.ir = ir; v.r1 = r1; v.r2 = r2;
        v.e_stall = es; v.e_bready = eb; v.e_rw = erw; v.e_wr = ewr; v.e_wd = ewd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_reg = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        issue_valid = 0; issue_reg = 0; readreg1 = 0; readreg2 = 0;
    endtask

    initial begin
        // av ar ad            bv br bd           iv ir  r1 r2  stall bready rw wr  wd
        tv[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF);
        tv[1]  = mk(0, 0, 0,            0, 0, 0,            1, 7, 0, 0, 0, 1, 0, 0, 0);
        tv[2]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 7, 0, 1, 1, 0, 0, 0);
        tv[3]  = mk(0, 0, 0,            1, 7, 32'h1234,     0, 0, 7, 0, 1, 1, 0, 0, 0);
        tv[4]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 7, 0, 1, 1, 1, 7, 32'h1234);
        tv[5]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 7, 0, 0, 1, 0, 0, 0);
        tv[6]  = mk(1, 1, 32'hA1,       1, 10, 32'hB0,      0, 0, 0, 0, 0, 1, 1, 1, 32'hA1);
        tv[7]  = mk(1, 2, 32'hA2,       1, 11, 32'hB1,      0, 0, 0, 0, 0, 1, 1, 2, 32'hA2);
        tv[8]  = mk(1, 3, 32'hA3,       1, 12, 32'hB2,      0, 0, 0, 0, 0, 0, 1, 3, 32'hA3);
        tv[9]  = mk(1, 4, 32'hA4,       1, 12, 32'hB2,      0, 0, 0, 0, 0, 0, 1, 4, 32'hA4);
        tv[10] = mk(0, 0, 0,            1, 12, 32'hB2,      0, 0, 0, 0, 0, 0, 1, 10, 32'hB0);
        tv[11] = mk(0, 0, 0,            1, 12, 32'hB2,      0, 0, 0, 0, 0, 1, 1, 11, 32'hB1);
        tv[12] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 1, 1, 12, 32'hB2);
        tv[13] = mk(1, 0, 32'h77,       1, 0, 32'h55,       0, 0, 0, 0, 0, 1, 0, 0, 0);
        tv[14] = mk(1, 0, 32'h77,       1, 0, 32'h56,       0, 0, 0, 0, 0, 1, 0, 0, 0);
        tv[15] = mk(0, 0, 0,            1, 3, 32'h99,       0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[16] = mk(0, 0, 0,            1, 3, 32'h99,       0, 0, 0, 0, 0, 1, 0, 0, 0);
        tv[17] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 1, 1, 3, 32'h99);
        tv[18] = mk(0, 0, 0,            1, 9, 32'h999,      0, 0, 0, 0, 0, 1, 0, 0, 0);
        tv[19] = mk(0, 0, 0,            0, 0, 0,            1, 9, 0, 0, 0, 1, 1, 9, 32'h999);
        tv[20] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 9, 1, 1, 0, 0, 0);
        tv[21] = mk(0, 0, 0,            0, 0, 0,            1, 9, 0, 0, 1, 1, 0, 0, 0);
        tv[22] = mk(0, 0, 0,            0, 0, 0,            1, 0, 0, 0, 0, 1, 0, 0, 0);

        // Reset held for three edges while B offers a result that must not be buffered.
        idle_inputs();
        reset = 0; b_valid = 1; b_reg = 4; b_data = 32'h4444;
        repeat (3) @(posedge clk);
        #1;
        reset = 1; b_valid = 0; readreg1 = 4;
        #1;
        chk("rst_regwrite",  {31'd0, regwrite}, 32'd0);
        chk("rst_writereg",  {27'd0, writereg}, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_b_ready",   {31'd0, b_ready}, 32'd1);
        chk("rst_stall",     {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("rst_no_residue", {31'd0, regwrite}, 32'd0);
`ifdef WB_CONFLICT_CNT_EN
        chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
`endif
        idle_inputs();

        for (int i = 0; i < 23; i++) begin
            a_valid = tv[i].av; a_reg = tv[i].ar; a_data = tv[i].ad;
            b_valid = tv[i].bv; b_reg = tv[i].br; b_data = tv[i].bd;
            issue_valid = tv[i].iv; issue_reg = tv[i].ir;
            readreg1 = tv[i].r1; readreg2 = tv[i].r2;
            #1;
            chk($sformatf("v%0d_stall", i),  {31'd0, stall},   {31'd0, tv[i].e_stall});
            chk($sformatf("v%0d_bready", i), {31'd0, b_ready}, {31'd0, tv[i].e_bready});
            @(posedge clk); #1;
            chk($sformatf("v%0d_regwrite", i), {31'd0, regwrite}, {31'd0, tv[i].e_rw});
            if (tv[i].e_rw) begin
                chk($sformatf("v%0d_writereg", i),  {27'd0, writereg}, {27'd0, tv[i].e_wr});
                chk($sformatf("v%0d_writedata", i), writedata, tv[i].e_wd);
            end
        end
`ifdef WB_CONFLICT_CNT_EN
        chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd4);
`endif

        // Fill the buffer behind A, then reset: buffered results and pend[9] must vanish.
        idle_inputs();
        a_valid = 1; a_reg = 1; a_data = 32'h11;
        b_valid = 1; b_reg = 20; b_data = 32'h20;
        @(posedge clk); #1;
        b_reg = 21; b_data = 32'h21;
        @(posedge clk); #1;
        chk("mid_full", {31'd0, b_ready}, 32'd0);
        idle_inputs();
        reset = 0;
        @(posedge clk); #1;
        reset = 1; readreg2 = 9;
        #1;
        chk("mid_b_ready", {31'd0, b_ready}, 32'd1);
        chk("mid_stall",   {31'd0, stall}, 32'd0);
        chk("mid_regwrite0", {31'd0, regwrite}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_drain%0d", k), {31'd0, regwrite}, 32'd0);
        end
`ifdef WB_CONFLICT_CNT_EN
        chk("mid_conflict", {16'd0, conflict_cnt}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
